// File: rtl/periph_bus_pkg.sv
// Shared definitions for the CPU-side peripheral bus master and its decoder.
// Latency: n/a (constants only).
// Backpressure: n/a.
package periph_bus_pkg;

  // Transaction state encoding (plain constants so legacy code can compare raw bits)
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  // I/O window: upper half-word that marks a peripheral access
  localparam logic [15:0] BASE_HI_DEF = 16'hFFFF;

  // Each peripheral owns one 4 KiB page
  localparam int PAGE_SHIFT = 12;

  // Timer register offsets within its page
  localparam logic [11:0] TMR_COMPARE = 12'h000;
  localparam logic [11:0] TMR_COUNTER = 12'h100;
  localparam logic [11:0] TMR_STATUS  = 12'h200;

endpackage

// File: rtl/periph_bus_master_if.sv
// Core request/response handshake plus peripheral strobe bus, bundled for port lists.
// Latency: n/a (wires only).
// Backpressure: req_ready gates requests; responses are never stalled.
// Ports: req_* (core -> master), resp_* (master -> core), CS_N/RD_N/WR_N/Addr/WData
//        (master -> slaves), RData (slaves -> master, slave n at [32n+31:32n]).
interface periph_bus_master_if #(
  parameter int NUM_SLAVES = 4
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [31:0]             req_addr;
  logic [31:0]             req_wdata;
  logic                    resp_valid;
  logic [31:0]             resp_rdata;
  logic                    resp_err;
  logic [NUM_SLAVES-1:0]   CS_N;
  logic                    RD_N;
  logic                    WR_N;
  logic [11:0]             Addr;
  logic [31:0]             WData;
  logic [NUM_SLAVES*32-1:0] RData;

  // Bus master side
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, RData,
    output req_ready, resp_valid, resp_rdata, resp_err,
           CS_N, RD_N, WR_N, Addr, WData
  );

  // Core + peripheral side
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, RData,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           CS_N, RD_N, WR_N, Addr, WData
  );
endinterface

// File: rtl/periph_addr_decode.sv
// Maps the page bits of a request address onto a peripheral index and hit flag.
// Latency: combinational.
// Backpressure: none.
// Ports: addr_hi (req_addr[31:12]) in; hit, idx out.
module periph_addr_decode
  import periph_bus_pkg::*;
#(
  parameter int          NUM_SLAVES = 4,
  parameter logic [15:0] BASE_HI    = BASE_HI_DEF
) (
  input  logic [31:PAGE_SHIFT] addr_hi,
  output logic                 hit,
  output logic [1:0]           idx
);

  localparam logic [2:0] NS = 3'(NUM_SLAVES);

  assign idx = addr_hi[PAGE_SHIFT+1:PAGE_SHIFT];

  // Only the first four pages above the base exist; pages beyond NUM_SLAVES miss
  assign hit = (addr_hi[31:16] == BASE_HI) &&
               (addr_hi[15:14] == 2'b00) &&
               ({1'b0, idx} < NS);

endmodule

// File: rtl/periph_bus_master.sv
// Single-outstanding initiator turning core loads/stores into CS_N/RD_N/WR_N strobes.
// Latency: accept->resp_valid load 3, store 2, decode miss 1 cycle(s).
// Backpressure: req_ready only in IDLE; resp_valid is a one-cycle pulse, not stallable.
// Ports: clk, reset (async active-low), bus (periph_bus_master_if.master).
module periph_bus_master
  import periph_bus_pkg::*;
#(
  parameter int          NUM_SLAVES = 4,
  parameter logic [15:0] BASE_HI    = BASE_HI_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  periph_bus_master_if.master  bus
);

  logic [1:0]  state;
  logic        wr_q;
  logic [1:0]  idx_q;
  logic        hit;
  logic [1:0]  idx;
  logic        accept;
  logic [31:0] rdata_sel;

  periph_addr_decode #(
    .NUM_SLAVES(NUM_SLAVES),
    .BASE_HI   (BASE_HI)
  ) u_decode (
    .addr_hi(bus.req_addr[31:PAGE_SHIFT]),
    .hit    (hit),
    .idx    (idx)
  );

  assign bus.req_ready = (state == IDLE);
  assign accept        = bus.req_valid && bus.req_ready;

  // Slaves drive 0 when deselected, so only the latched slave's word is meaningful
  always_comb begin
    rdata_sel = '0;
    for (int n = 0; n < NUM_SLAVES; n++) begin
      if (idx_q == 2'(n)) rdata_sel = bus.RData[n*32 +: 32];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      wr_q           <= 1'b0;
      idx_q          <= 2'd0;
      bus.CS_N       <= '1;
      bus.RD_N       <= 1'b1;
      bus.WR_N       <= 1'b1;
      bus.Addr       <= '0;
      bus.WData      <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      bus.resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            wr_q           <= bus.req_write;
            idx_q          <= idx;
            bus.Addr       <= bus.req_addr[PAGE_SHIFT-1:0];
            bus.WData      <= bus.req_wdata;
            bus.resp_rdata <= '0;
            bus.resp_err   <= !hit;
            if (hit) begin
              // Strobes are launched from flops on the accept edge so they are
              // low for exactly the ACCESS cycle and glitch-free
              state    <= ACCESS;
              bus.CS_N <= ~(NUM_SLAVES'(1) << idx);
              bus.RD_N <= bus.req_write;
              bus.WR_N <= !bus.req_write;
            end else begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
            end
          end
        end
        ACCESS: begin
          bus.CS_N <= '1;
          bus.RD_N <= 1'b1;
          bus.WR_N <= 1'b1;
          if (wr_q) begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
          end else begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          // Slave registered its DataOut on the ACCESS edge; it is valid only now
          bus.resp_rdata <= rdata_sel;
          bus.resp_valid <= 1'b1;
          state          <= RESP;
        end
        RESP: begin
          bus.resp_rdata <= '0;
          bus.resp_err   <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/periph_bus_master.md
Name: periph_bus_master

Overview:
- CPU-side initiator for the memory-mapped peripheral bus (CS_N/RD_N/WR_N/Addr strobes) used by the timer and other I/O slaves.
- Accepts one load/store request at a time from the multicycle core and decodes the address into a one-hot active-low chip select.
- Drives a single-cycle read or write strobe, then captures the slave's registered read data and returns a one-cycle response.
- Sits between the core's data-memory port mux and up to NUM_SLAVES peripherals at 0xFFFF_0000 + n*0x1000.

Parameters:
- NUM_SLAVES, 4, peripheral pages decoded; slave n at 0xFFFF_0000 + n*0x1000 (max 4).
- BASE_HI, 16'hFFFF, required value of req_addr[31:16] for an I/O hit.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  core request present
- req_ready  out  1  high only in IDLE; request accepted on clk edge with req_valid&req_ready
- req_write  in  1  1=store, 0=load
- req_addr  in  32  byte address (word-aligned)
- req_wdata  in  32  store data
- resp_valid  out  1  one-cycle pulse: transaction complete, no backpressure
- resp_rdata  out  32  load data (0 for stores and errors), valid with resp_valid
- resp_err  out  1  decode miss, valid with resp_valid
- CS_N  out  NUM_SLAVES  per-slave chip select, active-low, at most one low
- RD_N  out  1  read strobe, active-low
- WR_N  out  1  write strobe, active-low
- Addr  out  12  register offset within page (req_addr[11:0])
- WData  out  32  write data to slaves' DataIn
- RData  in  NUM_SLAVES*32  packed slave DataOut, slave n at [32n+31:32n]

Behaviour:
- Reset (async, while reset=0): state IDLE, CS_N all 1, RD_N=1, WR_N=1, Addr=0, WData=0, resp_valid=0, resp_rdata=0, resp_err=0. Any in-flight transaction is dropped with no response. req_ready=1 (state-derived).
- Decode at acceptance: hit iff req_addr[31:16]==BASE_HI and req_addr[15:14]==0 and req_addr[13:12]<NUM_SLAVES; idx=req_addr[13:12]. Latch write flag, idx, hit, Addr, and WData on the accept edge.
- State machine:
  - IDLE: req_ready=1. On accept, go to ACCESS if hit, else to RESP with err.
  - ACCESS: exactly one cycle with CS_N[idx]=0 and RD_N=0 (load) or WR_N=0 (store); Addr and WData stable. Next state is CAPTURE for a load, RESP for a store.
  - CAPTURE: all strobes high. Slave DataOut is valid this cycle only, because slaves clear it to 0 when not selected. Register RData[idx] into resp_rdata at the end of the cycle, then go to RESP.
  - RESP: resp_valid=1 for one cycle, then return to IDLE. resp_rdata=0 for stores and errors; resp_err=1 only on a decode miss.
- Strobes are registered outputs and glitch-free; never more than one CS_N low; RD_N and WR_N never low simultaneously; strobes never low outside ACCESS.
- Latency from the accept edge to resp_valid high: load 3 cycles, store 2 cycles, decode miss 1 cycle.
- Throughput: back-to-back loads 1 per 4 cycles, stores 1 per 3 cycles.
- req_valid is ignored outside IDLE. Request inputs may change after acceptance without affecting the transaction.
- Read side effects in a slave (e.g. status clear-on-read) occur exactly once per load because RD_N is low for one cycle only.
- Addr and WData hold their last value when idle; slaves must qualify on CS_N.

Decomposition:
- Shared package periph_bus_pkg holds:
  - state enum (IDLE, ACCESS, CAPTURE, RESP)
  - BASE_HI default
  - PAGE_SHIFT=12
  - timer register offsets: COMPARE=12'h000, COUNTER=12'h100, STATUS=12'h200
- One natural sub-module: periph_addr_decode (combinational; req_addr -> hit, idx).

Test Plan:
- Store 0x0000_0010 to 0xFFFF_0000 -> CS_N=4'b1110 and WR_N=0 for exactly 1 cycle with Addr=0x000 and WData=0x10; resp_valid 2 cycles after accept with rdata=0, err=0.
- Load 0xFFFF_1100 with slave1 returning 0xCAFE_0001 in CAPTURE -> RD_N low 1 cycle with CS_N=4'b1101 and Addr=0x100; resp_rdata=0xCAFE_0001 at cycle 3.
- Load 0x1234_0000 or 0xFFFF_4000 -> no strobe ever asserted; resp_valid 1 cycle after accept with err=1, rdata=0.
- req_valid held high for 3 loads -> accepts spaced 4 cycles apart; each RD_N pulse is 1 cycle; the timer status-read pulse clears StatusR exactly once.
- Assert reset during ACCESS of a store -> WR_N and CS_N go high asynchronously; no resp_valid; after release req_ready=1 and a new load completes normally.
- Random stimulus with assertions: at most one CS_N low, never RD_N&WR_N low together, exactly one resp_valid per accepted request.
